// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding (IEEE 1149.1 codes)
// and the default instruction register length.
package jtag_pkg;

    localparam int unsigned IR_LEN_DEF = 2;

    typedef enum logic [3:0] {
        S_TLR   = 4'hF,
        S_RTI   = 4'hC,
        S_SELDR = 4'h7,
        S_CAPDR = 4'h6,
        S_SHDR  = 4'h2,
        S_EX1DR = 4'h1,
        S_PAUDR = 4'h3,
        S_EX2DR = 4'h0,
        S_UPDDR = 4'h5,
        S_SELIR = 4'h4,
        S_CAPIR = 4'hE,
        S_SHIR  = 4'hA,
        S_EX1IR = 4'h9,
        S_PAUIR = 4'hB,
        S_EX2IR = 4'h8,
        S_UPDIR = 4'hD
    } tap_state_t;

endpackage

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller with an IR shift-length checker.
// Ports: TCK clock, Reset sync active-high, TMS mode select;
//   State (4b IEEE code), Moore-decoded IR/DR capture/shift/update
//   strobes, ClockIR/ClockDR, Select (IR column), Enable (TDO enable,
//   one cycle after a shift state), IRBitCount, IRLengthError (sticky).
module tap_controller
    import jtag_pkg::*;
#(
    parameter int unsigned IR_LEN = IR_LEN_DEF,
    parameter int unsigned CNT_W  = 4
) (
    input  logic             TCK,
    input  logic             Reset,
    input  logic             TMS,
    output logic [3:0]       State,
    output logic             TestLogicReset,
    output logic             CaptureIR,
    output logic             ShiftIR,
    output logic             ClockIR,
    output logic             UpdateIR,
    output logic             CaptureDR,
    output logic             ShiftDR,
    output logic             ClockDR,
    output logic             UpdateDR,
    output logic             Select,
    output logic             Enable,
    output logic [CNT_W-1:0] IRBitCount,
    output logic             IRLengthError
);

    tap_state_t       state;
    tap_state_t       state_nxt;
    logic [CNT_W-1:0] ir_cnt;
    logic             ir_err;
    logic             en_q;

    always_ff @(posedge TCK) begin
        if (Reset) begin
            state <= S_TLR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_TLR:   state_nxt = TMS ? S_TLR   : S_RTI;
            S_RTI:   state_nxt = TMS ? S_SELDR : S_RTI;
            S_SELDR: state_nxt = TMS ? S_SELIR : S_CAPDR;
            S_CAPDR: state_nxt = TMS ? S_EX1DR : S_SHDR;
            S_SHDR:  state_nxt = TMS ? S_EX1DR : S_SHDR;
            S_EX1DR: state_nxt = TMS ? S_UPDDR : S_PAUDR;
            S_PAUDR: state_nxt = TMS ? S_EX2DR : S_PAUDR;
            S_EX2DR: state_nxt = TMS ? S_UPDDR : S_SHDR;
            S_UPDDR: state_nxt = TMS ? S_SELDR : S_RTI;
            S_SELIR: state_nxt = TMS ? S_TLR   : S_CAPIR;
            S_CAPIR: state_nxt = TMS ? S_EX1IR : S_SHIR;
            S_SHIR:  state_nxt = TMS ? S_EX1IR : S_SHIR;
            S_EX1IR: state_nxt = TMS ? S_UPDIR : S_PAUIR;
            S_PAUIR: state_nxt = TMS ? S_EX2IR : S_PAUIR;
            S_EX2IR: state_nxt = TMS ? S_UPDIR : S_SHIR;
            S_UPDIR: state_nxt = TMS ? S_SELDR : S_RTI;
        endcase
    end

    // TDO enable trails the shift states by one TCK.
    always_ff @(posedge TCK) begin
        if (Reset) begin
            en_q <= 1'b0;
        end else begin
            en_q <= (state == S_SHIR) || (state == S_SHDR);
        end
    end

    // IR scan length checker; counter saturates so long scans
    // still read as a mismatch.
    always_ff @(posedge TCK) begin
        if (Reset) begin
            ir_cnt <= '0;
            ir_err <= 1'b0;
        end else begin
            if (state == S_CAPIR) begin
                ir_cnt <= '0;
            end else if (state == S_SHIR && ir_cnt != '1) begin
                ir_cnt <= ir_cnt + 1'b1;
            end
            if (state == S_TLR) begin
                ir_err <= 1'b0;
            end else if (state == S_UPDIR
                         && ir_cnt != CNT_W'(IR_LEN)) begin
                ir_err <= 1'b1;
            end
        end
    end

    assign State          = state;
    assign TestLogicReset = (state == S_TLR);
    assign CaptureIR      = (state == S_CAPIR);
    assign ShiftIR        = (state == S_SHIR);
    assign ClockIR        = CaptureIR | ShiftIR;
    assign UpdateIR       = (state == S_UPDIR);
    assign CaptureDR      = (state == S_CAPDR);
    assign ShiftDR        = (state == S_SHDR);
    assign ClockDR        = CaptureDR | ShiftDR;
    assign UpdateDR       = (state == S_UPDDR);
    assign Select         = (state == S_SELIR) || (state == S_CAPIR)
                         || (state == S_SHIR)  || (state == S_EX1IR)
                         || (state == S_PAUIR) || (state == S_EX2IR)
                         || (state == S_UPDIR);
    assign Enable         = en_q;
    assign IRBitCount     = ir_cnt;
    // Being in TLR already means the flag is being cleared.
    assign IRLengthError  = ir_err && (state != S_TLR);

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller: expected states are queued
// as TMS is driven and compared after each rising TCK.
module tb_tap_controller;

    logic       TCK = 1'b0;
    logic       Reset = 1'b0;
    logic       TMS = 1'b1;
    logic [3:0] State;
    logic       TestLogicReset, CaptureIR, ShiftIR, ClockIR, UpdateIR;
    logic       CaptureDR, ShiftDR, ClockDR, UpdateDR, Select, Enable;
    logic [3:0] IRBitCount;
    logic       IRLengthError;

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] exp_q[$];

    tap_controller #(.IR_LEN(2), .CNT_W(4)) dut (
        .TCK(TCK), .Reset(Reset), .TMS(TMS), .State(State),
        .TestLogicReset(TestLogicReset), .CaptureIR(CaptureIR),
        .ShiftIR(ShiftIR), .ClockIR(ClockIR), .UpdateIR(UpdateIR),
        .CaptureDR(CaptureDR), .ShiftDR(ShiftDR), .ClockDR(ClockDR),
        .UpdateDR(UpdateDR), .Select(Select), .Enable(Enable),
        .IRBitCount(IRBitCount), .IRLengthError(IRLengthError)
    );

    always #5 TCK = ~TCK;

    // Drive one TMS value, queue the expected state, compare after edge.
    task automatic tick(input logic tms, input logic [3:0] exp_st);
        logic [3:0] e;
        TMS = tms;
        exp_q.push_back(exp_st);
        @(posedge TCK);
        #1;
        e = exp_q.pop_front();
        vectors++;
        if (State !== e) begin
            miscompares++;
            $display("FAIL state: got %h want %h", State, e);
        end
    endtask

    task automatic drive(input logic tms);
        TMS = tms;
        @(posedge TCK);
        #1;
    endtask

    task automatic rst_tick();
        Reset = 1'b1;
        tick(1'b1, 4'hF);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        rst_tick();
        tick(0, 4'hC); tick(1, 4'h7); tick(0, 4'h6); tick(0, 4'h2);
        Reset = 1'b1;
        tick(1'b0, 4'hF);
        Reset = 1'b0;
        vectors++;
        if ({TestLogicReset, ShiftDR, Enable} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_outs: got %b want 100",
                     {TestLogicReset, ShiftDR, Enable});
        end
    endtask

    task automatic test_tms_reset();
        string      path [16];
        logic [3:0] tgt  [16];
        path = '{"", "0", "01", "010", "0100", "0101", "01010",
                 "010101", "01011", "011", "0110", "01100", "01101",
                 "011010", "0110101", "011011"};
        tgt  = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3,
                 4'h0, 4'h5, 4'h4, 4'hE, 4'hA, 4'h9,
                 4'hB, 4'h8, 4'hD};
        for (int s = 0; s < 16; s++) begin
            rst_tick();
            for (int i = 0; i < path[s].len(); i++)
                drive(path[s][i] == "1");
            vectors++;
            if (State !== tgt[s]) begin
                miscompares++;
                $display("FAIL path%0d: got %h want %h", s, State, tgt[s]);
            end
            for (int i = 0; i < 4; i++) drive(1'b1);
            tick(1'b1, 4'hF);
        end
    endtask

    task automatic test_ir_scan();
        logic       tms [8] = '{1, 1, 0, 0, 0, 1, 1, 0};
        logic [3:0] st  [8] = '{4'h7, 4'h4, 4'hE, 4'hA,
                                4'hA, 4'h9, 4'hD, 4'hC};
        logic       sel [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
        int clk_ir = 0;
        int upd_ir = 0;
        rst_tick();
        tick(0, 4'hC);
        for (int i = 0; i < 8; i++) begin
            tick(tms[i], st[i]);
            clk_ir += int'(ClockIR);
            upd_ir += int'(UpdateIR);
            vectors++;
            if (Select !== sel[i]) begin
                miscompares++;
                $display("FAIL ir_select%0d: got %b want %b",
                         i, Select, sel[i]);
            end
        end
        vectors++;
        if (clk_ir != 3 || upd_ir != 1) begin
            miscompares++;
            $display("FAIL ir_strobes: clockir %0d upd %0d want 3 1",
                     clk_ir, upd_ir);
        end
        vectors++;
        if (IRBitCount !== 4'd2 || IRLengthError !== 1'b0) begin
            miscompares++;
            $display("FAIL ir_len_ok: cnt %0d err %b want 2 0",
                     IRBitCount, IRLengthError);
        end
    endtask

    task automatic test_ir_len_error();
        tick(1, 4'h7); tick(1, 4'h4); tick(0, 4'hE); tick(0, 4'hA);
        tick(0, 4'hA); tick(0, 4'hA); tick(1, 4'h9); tick(1, 4'hD);
        tick(0, 4'hC);
        vectors++;
        if (IRBitCount !== 4'd3 || IRLengthError !== 1'b1) begin
            miscompares++;
            $display("FAIL ir_len_bad: cnt %0d err %b want 3 1",
                     IRBitCount, IRLengthError);
        end
        tick(1, 4'h7); tick(1, 4'h4); tick(0, 4'hE); tick(0, 4'hA);
        tick(0, 4'hA); tick(1, 4'h9); tick(1, 4'hD); tick(0, 4'hC);
        vectors++;
        if (IRBitCount !== 4'd2 || IRLengthError !== 1'b1) begin
            miscompares++;
            $display("FAIL ir_sticky: cnt %0d err %b want 2 1",
                     IRBitCount, IRLengthError);
        end
        tick(1, 4'h7); tick(1, 4'h4); tick(1, 4'hF);
        tick(1, 4'hF); tick(1, 4'hF);
        vectors++;
        if (IRLengthError !== 1'b0) begin
            miscompares++;
            $display("FAIL ir_err_clear: got %b want 0", IRLengthError);
        end
    endtask

    task automatic test_dr_pause();
        logic       tms [10] = '{1, 0, 0, 0, 1, 0, 1, 0, 1, 1};
        logic [3:0] st  [10] = '{4'h7, 4'h6, 4'h2, 4'h2, 4'h1,
                                 4'h3, 4'h0, 4'h2, 4'h1, 4'h5};
        logic       en  [10] = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 0};
        tick(0, 4'hC);
        for (int i = 0; i < 10; i++) begin
            tick(tms[i], st[i]);
            vectors++;
            if (Select !== 1'b0 || Enable !== en[i]) begin
                miscompares++;
                $display("FAIL dr_step%0d: sel %b en %b want 0 %b",
                         i, Select, Enable, en[i]);
            end
        end
    endtask

    task automatic test_ir_saturate();
        tick(0, 4'hC);
        tick(1, 4'h7); tick(1, 4'h4); tick(0, 4'hE);
        for (int i = 0; i < 20; i++) tick(0, 4'hA);
        tick(1, 4'h9);
        vectors++;
        if (IRBitCount !== 4'd15) begin
            miscompares++;
            $display("FAIL ir_sat: got %0d want 15", IRBitCount);
        end
        tick(1, 4'hD); tick(0, 4'hC);
        vectors++;
        if (IRBitCount !== 4'd15 || IRLengthError !== 1'b1) begin
            miscompares++;
            $display("FAIL ir_sat_err: cnt %0d err %b want 15 1",
                     IRBitCount, IRLengthError);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_tms_reset();
        test_ir_scan();
        test_ir_len_error();
        test_dr_pause();
        test_ir_saturate();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
